string_hw_csr: RTL and testbench
================================

# string_hw_csr

Avalon-MM register front end that sits directly upstream of the `String_HW` string accelerator inside the Nios II system. It stages operand strings, opcode and length written by software. It runs the accelerator's go/done handshake, captures the result bytes and raises a sticky completion flag with an optional interrupt. It also guards against invalid requests and against an accelerator that never reports done.

## Interface
Parameters:
- `MAX_BLOCKS`, 2, number of 32-bit words per string; string length is `MAX_BLOCKS*4` bytes.
- `TIMEOUT_CYCLES`, 64, number of cycles with `go` high and no `done` before the request is aborted.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high.
- `address`  in  4  word address, decoded below.
- `read`, `write`  in  1 each  Avalon strobes.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data, read latency 1.
- `irq`  out  1  equals `done_flag & irq_en`.
- `go`  out  1  request to the accelerator.
- `index`  out  4  opcode: 0 cmp, 1 upper, 2 lower, 3 reverse, 4 search.
- `length`  out  8  search pattern length.
- `A`, `B`  out  `[0:MAX_BLOCKS*4-1][7:0]`  operand strings.
- `done`  in  1  accelerator completion.
- `Result`  in  `[0:MAX_BLOCKS*4-1][7:0]`  accelerator result.

## Operation
- Register map (word addresses, default `MAX_BLOCKS`=2):
  - 0 CTRL: write bit0 = start, [7:4] = index, [15:8] = length, bit16 = irq_en; reads back index, length and irq_en, with bit0 reading as 0.
  - 1 STATUS: bit0 busy, bit1 done_flag, bit2 error, [5:4] err_code (1 = bad index, 2 = bad length, 3 = timeout). Writing 1 to bit1 clears done_flag; writing 1 to bit2 clears error and err_code.
  - 2..3 A words, 4..5 B words: read/write.
  - 6..7 RES words: read-only.
  - Unmapped addresses read 0; writes to them are ignored.
- Byte mapping: word k, bits [8b+7:8b] maps to string byte `4k+b`. This makes byte 0 the lowest memory address of a little-endian C string. RES uses the same mapping, passed through from `Result` unchanged.
- State machine states: IDLE, RUN, CAPTURE, RELEASE.
  - IDLE, start written: if index > 4, set error with code 1 and stay in IDLE. If index == 4 and length is 0 or greater than `MAX_BLOCKS*4`, set error with code 2 and stay in IDLE. Otherwise clear done_flag, error and RES, assert `go`, clear the timeout counter and go to RUN.
  - RUN: if `done`=1, go to CAPTURE. If the counter reaches `TIMEOUT_CYCLES-1`, drop `go`, set error with code 3 and go to RELEASE.
  - CAPTURE: latch `Result` into RES, drop `go`, set done_flag, go to RELEASE.
  - RELEASE: wait for `done`=0, then go to IDLE.
- busy = (state != IDLE).
- While busy:
  - Writes to CTRL (including start), A and B are ignored.
  - STATUS clear writes still take effect.
  - Reads are always serviced.
- The outputs `A`, `B`, `index` and `length` drive directly from the registers and are stable for the whole of RUN.

## Timing
- Reset values: `go`=0, `irq`=0, `readdata`=0, `index`=0, `length`=0, `A`=0, `B`=0, RES=0, all status bits 0, state IDLE.
- `go` rises on the cycle after the start write, if the write is accepted.
- `done` seen high at edge n: RES and done_flag update at edge n+1, and `go` is 0 from edge n+1.
- `irq` is combinational from the flags and follows done_flag in the same cycle.
- `readdata` is valid on the cycle after `read`. A read and a write in the same cycle are both performed; the read returns the pre-write value.
- Reset asserted mid-operation: everything returns to reset values on the next edge and `go` drops immediately. The accelerator shares `reset`.
- The counter width is `$clog2(TIMEOUT_CYCLES)`; the counter saturates and does not wrap.

## Structure
- Shared package `string_hw_pkg` holds:
  - `MAX_BLOCKS`,
  - opcode constants (`OP_CMP`..`OP_SEARCH`),
  - register address constants,
  - error code constants,
  - the FSM state enum.
- No sub-module is needed: the register file, FSM and timeout counter are inline. The `String_HW` instance is wired beside this block at system level.

## Test plan
- Upper-case: A=0x64636261, 0x215A5958 ("abcdXYZ!"), start index 1 → `go` pulse, RES = 0x44434241, 0x215A5958, STATUS=0x2, `irq`=1 when irq_en is set.
- Search: A="hello wo", B="ll", length 2, index 4 → RES[7] (word 7 bits 31:24) = 0x02, done_flag set.
- Bad requests: start with index 7 → STATUS=0x14 and `go` never rises. Start with index 4 and length 0 → err_code 2.
- Timeout: model holds `done`=0 → `go` falls after 64 cycles, STATUS error with code 3, RES stays 0, returns to IDLE.
- Busy protection: write A and issue start while in RUN → A, index and `go` are unchanged. Assert reset mid-RUN → `go`=0 and all registers read 0.

Source files
------------

// File: rtl/string_hw_pkg.sv
// string_hw_pkg: constants and types shared by the String_HW front end.
// Opcodes, register addresses, error codes and FSM states.
package string_hw_pkg;

   localparam int MAX_BLOCKS = 2;

   localparam logic [3:0] OP_CMP     = 4'd0;
   localparam logic [3:0] OP_UPPER   = 4'd1;
   localparam logic [3:0] OP_LOWER   = 4'd2;
   localparam logic [3:0] OP_REVERSE = 4'd3;
   localparam logic [3:0] OP_SEARCH  = 4'd4;

   localparam int ADDR_CTRL   = 0;
   localparam int ADDR_STATUS = 1;
   localparam int ADDR_A0     = 2;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_INDEX   = 2'd1;
   localparam logic [1:0] ERR_LENGTH  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_CAPTURE,
      S_RELEASE
   } state_t;

endpackage

// File: rtl/string_hw_csr.sv
// string_hw_csr: Avalon-MM register front end for String_HW.
// Stages operands, runs go/done and captures the result.
module string_hw_csr #(
   parameter int MAX_BLOCKS     = string_hw_pkg::MAX_BLOCKS,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [3:0]                      address,
   input  logic                            read,
   input  logic                            write,
   input  logic [31:0]                     writedata,
   output logic [31:0]                     readdata,
   output logic                            irq,
   output logic                            go,
   output logic [3:0]                      index,
   output logic [7:0]                      length,
   output logic [0:MAX_BLOCKS*4-1][7:0]    A,
   output logic [0:MAX_BLOCKS*4-1][7:0]    B,
   input  logic                            done,
   input  logic [0:MAX_BLOCKS*4-1][7:0]    Result
);

   import string_hw_pkg::*;

   localparam int NB = MAX_BLOCKS * 4;
   localparam int CW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int ADDR_B0 = ADDR_A0 + MAX_BLOCKS;
   localparam int ADDR_R0 = ADDR_B0 + MAX_BLOCKS;
   localparam logic [CW-1:0] CNT_LAST =
      CW'(TIMEOUT_CYCLES - 1);

   state_t                state;
   logic [CW-1:0]         cnt;
   logic                  irq_en;
   logic                  done_flag;
   logic                  error;
   logic [1:0]            err_code;
   logic [0:NB-1][7:0]    res;
   logic [31:0]           rd_mux;
   logic                  busy;
   int                    adr;
   logic [3:0]            wr_idx;
   logic [7:0]            wr_len;
   logic                  start;
   logic                  bad_idx;
   logic                  bad_len;

   assign adr     = int'(address);
   assign busy    = (state != S_IDLE);
   assign irq     = done_flag & irq_en;
   assign wr_idx  = writedata[7:4];
   assign wr_len  = writedata[15:8];
   assign start   = write && !busy &&
                    (adr == ADDR_CTRL) && writedata[0];
   assign bad_idx = (wr_idx > OP_SEARCH);
   assign bad_len = (wr_idx == OP_SEARCH) &&
                    ((wr_len == 8'd0) || (int'(wr_len) > NB));

   // Read mux: selects the register image for the addressed word.
   always_comb begin
      rd_mux = '0;
      if (adr == ADDR_CTRL)
         rd_mux = {15'd0, irq_en, length, index, 4'd0};
      else if (adr == ADDR_STATUS)
         rd_mux = {26'd0, err_code, 1'b0,
                   error, done_flag, busy};
      for (int k = 0; k < MAX_BLOCKS; k++) begin
         for (int b = 0; b < 4; b++) begin
            if (adr == ADDR_A0 + k)
               rd_mux[8*b +: 8] = A[4*k + b];
            if (adr == ADDR_B0 + k)
               rd_mux[8*b +: 8] = B[4*k + b];
            if (adr == ADDR_R0 + k)
               rd_mux[8*b +: 8] = res[4*k + b];
         end
      end
   end

   // Register file, handshake FSM and timeout counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         readdata  <= '0;
         go        <= 1'b0;
         index     <= '0;
         length    <= '0;
         irq_en    <= 1'b0;
         done_flag <= 1'b0;
         error     <= 1'b0;
         err_code  <= ERR_NONE;
         A         <= '0;
         B         <= '0;
         res       <= '0;
      end else begin
         if (read)
            readdata <= rd_mux;

         if (write && adr == ADDR_STATUS) begin
            if (writedata[1])
               done_flag <= 1'b0;
            if (writedata[2]) begin
               error    <= 1'b0;
               err_code <= ERR_NONE;
            end
         end

         if (write && !busy) begin
            if (adr == ADDR_CTRL) begin
               index  <= wr_idx;
               length <= wr_len;
               irq_en <= writedata[16];
            end
            for (int k = 0; k < MAX_BLOCKS; k++) begin
               for (int b = 0; b < 4; b++) begin
                  if (adr == ADDR_A0 + k)
                     A[4*k + b] <= writedata[8*b +: 8];
                  if (adr == ADDR_B0 + k)
                     B[4*k + b] <= writedata[8*b +: 8];
               end
            end
         end

         unique case (state)
            S_IDLE: begin
               if (start) begin
                  if (bad_idx) begin
                     error    <= 1'b1;
                     err_code <= ERR_INDEX;
                  end else if (bad_len) begin
                     error    <= 1'b1;
                     err_code <= ERR_LENGTH;
                  end else begin
                     done_flag <= 1'b0;
                     error     <= 1'b0;
                     err_code  <= ERR_NONE;
                     res       <= '0;
                     go        <= 1'b1;
                     cnt       <= '0;
                     state     <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (done) begin
                  state <= S_CAPTURE;
               end else if (cnt == CNT_LAST) begin
                  go       <= 1'b0;
                  error    <= 1'b1;
                  err_code <= ERR_TIMEOUT;
                  state    <= S_RELEASE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_CAPTURE: begin
               res       <= Result;
               go        <= 1'b0;
               done_flag <= 1'b1;
               state     <= S_RELEASE;
            end
            S_RELEASE: begin
               if (!done)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_string_hw_csr.sv
// tb_string_hw_csr: bench for string_hw_csr with a String_HW
// stand-in that answers go with a string operation result.
module tb_string_hw_csr;

   localparam int MB = 2;
   localparam int NB = MB * 4;
   localparam int TO = 64;

   typedef logic [0:NB-1][7:0] str_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   logic        go;
   logic [3:0]  index;
   logic [7:0]  length;
   str_t        A;
   str_t        B;
   logic        done;
   str_t        Result;

   int n_cmp = 0;
   int n_bad = 0;
   int acc_delay = 0;
   int acc_cnt;
   bit acc_hang = 0;

   always #5 clk = ~clk;

   string_hw_csr #(
      .MAX_BLOCKS(MB),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .read(read),
      .write(write),
      .writedata(writedata),
      .readdata(readdata),
      .irq(irq),
      .go(go),
      .index(index),
      .length(length),
      .A(A),
      .B(B),
      .done(done),
      .Result(Result)
   );

   // String operations as the accelerator defines them.
   function automatic str_t ref_op(input int op, input int len,
                                   input str_t a, input str_t b);
      str_t r;
      int   pos;
      bit   hit;
      r = '0;
      case (op)
         0: begin
            r[0] = (a == b) ? 8'h00 : 8'h01;
         end
         1: for (int i = 0; i < NB; i++)
               r[i] = (a[i] >= 8'h61 && a[i] <= 8'h7a)
                      ? a[i] - 8'd32 : a[i];
         2: for (int i = 0; i < NB; i++)
               r[i] = (a[i] >= 8'h41 && a[i] <= 8'h5a)
                      ? a[i] + 8'd32 : a[i];
         3: for (int i = 0; i < NB; i++)
               r[i] = a[NB-1-i];
         default: begin
            pos = 255;
            for (int p = NB - len; p >= 0; p--) begin
               hit = 1;
               for (int i = 0; i < len; i++)
                  if (a[p+i] != b[i]) hit = 0;
               if (hit) pos = p;
            end
            r[NB-1] = pos[7:0];
         end
      endcase
      return r;
   endfunction

   function automatic logic [31:0] word_of(input str_t s,
                                           input int k);
      return {s[4*k+3], s[4*k+2], s[4*k+1], s[4*k]};
   endfunction

   // Accelerator stand-in: done after acc_delay cycles, held until go drops.
   always @(posedge clk) begin
      if (reset) begin
         done    <= 1'b0;
         acc_cnt <= 0;
         Result  <= '0;
      end else if (go && !done && !acc_hang) begin
         if (acc_cnt >= acc_delay) begin
            Result  <= ref_op(int'(index), int'(length), A, B);
            done    <= 1'b1;
            acc_cnt <= 0;
         end else begin
            acc_cnt <= acc_cnt + 1;
         end
      end else if (!go && done) begin
         done <= 1'b0;
      end
   end

   task automatic bus_write(input int a, input logic [31:0] d);
      @(negedge clk);
      address   = a[3:0];
      writedata = d;
      write     = 1'b1;
      @(negedge clk);
      write     = 1'b0;
   endtask

   task automatic bus_read(input int a, output logic [31:0] d);
      @(negedge clk);
      address = a[3:0];
      read    = 1'b1;
      @(negedge clk);
      read    = 1'b0;
      d       = readdata;
   endtask

   task automatic load(input str_t a, input str_t b);
      for (int k = 0; k < MB; k++) begin
         bus_write(2 + k, word_of(a, k));
         bus_write(2 + MB + k, word_of(b, k));
      end
   endtask

   task automatic start(input int op, input int len,
                        input bit ie);
      logic [31:0] w;
      w = {15'd0, ie, len[7:0], op[3:0], 4'd1};
      bus_write(0, w);
   endtask

   task automatic wait_idle(output bit ok);
      logic [31:0] st;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         bus_read(1, st);
         if (st[0] == 1'b0) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({go, irq, index, length} !== 14'd0 ||
          readdata !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_out: go=%b irq=%b rd=%h",
                  go, irq, readdata);
      end
      n_cmp++;
      if (A !== '0 || B !== '0) begin
         n_bad++;
         $display("FAIL reset_str: A=%h B=%h want 0", A, B);
      end
      reset = 1'b0;
      for (int a = 0; a < 16; a++) begin
         bus_read(a, d);
         n_cmp++;
         if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_reg%0d: got %h want 0", a, d);
         end
      end
   endtask

   task automatic test_upper();
      str_t a;
      logic [31:0] d;
      bit ok;
      a = {8'h61, 8'h62, 8'h63, 8'h64,
           8'h58, 8'h59, 8'h5a, 8'h21};
      load(a, '0);
      n_cmp++;
      if (A !== a) begin
         n_bad++;
         $display("FAIL upper_A: got %h want %h", A, a);
      end
      acc_delay = 3;
      start(1, 0, 1'b1);
      n_cmp++;
      if (go !== 1'b1) begin
         n_bad++;
         $display("FAIL upper_go: got %b want 1", go);
      end
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL upper_wait: got busy want idle");
      end
      bus_read(6, d);
      n_cmp++;
      if (d !== 32'h44434241) begin
         n_bad++;
         $display("FAIL upper_res0: got %h want 44434241", d);
      end
      bus_read(7, d);
      n_cmp++;
      if (d !== 32'h215a5958) begin
         n_bad++;
         $display("FAIL upper_res1: got %h want 215a5958", d);
      end
      bus_read(1, d);
      n_cmp++;
      if (d !== 32'h2 || irq !== 1'b1) begin
         n_bad++;
         $display("FAIL upper_stat: got %h irq=%b want 2 1",
                  d, irq);
      end
      bus_write(1, 32'h2);
      n_cmp++;
      if (irq !== 1'b0) begin
         n_bad++;
         $display("FAIL upper_irqclr: got %b want 0", irq);
      end
   endtask

   task automatic test_search();
      str_t a, b;
      logic [31:0] d;
      bit ok;
      a = {8'h68, 8'h65, 8'h6c, 8'h6c,
           8'h6f, 8'h20, 8'h77, 8'h6f};
      b = {8'h6c, 8'h6c, 48'd0};
      load(a, b);
      acc_delay = 0;
      start(4, 2, 1'b0);
      wait_idle(ok);
      bus_read(7, d);
      n_cmp++;
      if (!ok || d !== 32'h02000000) begin
         n_bad++;
         $display("FAIL search_res1: got %h want 02000000", d);
      end
      bus_read(1, d);
      n_cmp++;
      if (d !== 32'h2 || irq !== 1'b0) begin
         n_bad++;
         $display("FAIL search_stat: got %h irq=%b want 2 0",
                  d, irq);
      end
   endtask

   task automatic test_random();
      str_t a, b, e;
      logic [31:0] d, c;
      int op, len, p;
      bit ie, ok;
      for (int it = 0; it < 12; it++) begin
         op  = $urandom_range(0, 4);
         len = (op == 4) ? $urandom_range(1, NB) : $urandom_range(0, 255);
         ie  = 1'($urandom_range(0, 1));
         for (int i = 0; i < NB; i++) begin
            a[i] = 8'($urandom_range(32, 126));
            b[i] = 8'($urandom_range(32, 126));
         end
         if (op == 0 && $urandom_range(0, 1) == 1) b = a;
         if (op == 4 && $urandom_range(0, 1) == 1) begin
            p = $urandom_range(0, NB - len);
            for (int i = 0; i < len; i++) b[i] = a[p+i];
         end
         e = ref_op(op, len, a, b);
         load(a, b);
         acc_delay = $urandom_range(0, 6);
         start(op, len, ie);
         n_cmp++;
         if (go !== 1'b1 || A !== a || B !== b) begin
            n_bad++;
            $display("FAIL rand%0d_go: go=%b A=%h want %h",
                     it, go, A, a);
         end
         wait_idle(ok);
         bus_read(0, c);
         n_cmp++;
         if (!ok || c !== {15'd0, ie, len[7:0], op[3:0], 4'd0}) begin
            n_bad++;
            $display("FAIL rand%0d_ctrl: got %h op=%0d len=%0d",
                     it, c, op, len);
         end
         bus_read(1, d);
         n_cmp++;
         if (d !== 32'h2 || irq !== ie) begin
            n_bad++;
            $display("FAIL rand%0d_stat: got %h irq=%b want 2 %b",
                     it, d, irq, ie);
         end
         for (int k = 0; k < MB; k++) begin
            bus_read(2 + 2 * MB + k, d);
            n_cmp++;
            if (d !== word_of(e, k)) begin
               n_bad++;
               $display("FAIL rand%0d_res%0d: got %h want %h",
                        it, k, d, word_of(e, k));
            end
         end
      end
   endtask

   task automatic test_bad();
      logic [31:0] d;
      bit sawgo;
      bit ok;
      bus_write(1, 32'h6);
      start(7, 0, 1'b0);
      sawgo = 0;
      repeat (5) begin
         @(negedge clk);
         if (go !== 1'b0) sawgo = 1;
      end
      bus_read(1, d);
      n_cmp++;
      if (d !== 32'h14 || sawgo) begin
         n_bad++;
         $display("FAIL bad_index: got %h go=%b want 14 0",
                  d, sawgo);
      end
      bus_write(1, 32'h4);
      bus_read(1, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_bad++;
         $display("FAIL bad_clear: got %h want 0", d);
      end
      start(4, 0, 1'b0);
      bus_read(1, d);
      n_cmp++;
      if (d !== 32'h24 || go !== 1'b0) begin
         n_bad++;
         $display("FAIL bad_len0: got %h want 24", d);
      end
      bus_write(1, 32'h4);
      start(4, NB + 1, 1'b0);
      bus_read(1, d);
      n_cmp++;
      if (d !== 32'h24 || go !== 1'b0) begin
         n_bad++;
         $display("FAIL bad_len9: got %h want 24", d);
      end
      start(4, NB, 1'b0);
      wait_idle(ok);
      bus_read(1, d);
      n_cmp++;
      if (!ok || d !== 32'h2) begin
         n_bad++;
         $display("FAIL len_max: got %h want 2", d);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] d;
      int cyc;
      bit ok;
      acc_hang = 1;
      start(2, 0, 1'b0);
      cyc = 0;
      while (go === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      n_cmp++;
      if (cyc != TO) begin
         n_bad++;
         $display("FAIL timeout_len: got %0d want %0d", cyc, TO);
      end
      wait_idle(ok);
      bus_read(1, d);
      n_cmp++;
      if (!ok || d !== 32'h34) begin
         n_bad++;
         $display("FAIL timeout_stat: got %h want 34", d);
      end
      for (int k = 0; k < MB; k++) begin
         bus_read(2 + 2 * MB + k, d);
         n_cmp++;
         if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL timeout_res%0d: got %h want 0", k, d);
         end
      end
      acc_hang = 0;
      bus_write(1, 32'h4);
   endtask

   task automatic test_rw_same();
      logic [31:0] x, y, d;
      x = $urandom;
      y = ~x;
      bus_write(2, x);
      @(negedge clk);
      address   = 4'd2;
      writedata = y;
      write     = 1'b1;
      read      = 1'b1;
      @(negedge clk);
      write = 1'b0;
      read  = 1'b0;
      n_cmp++;
      if (readdata !== x) begin
         n_bad++;
         $display("FAIL rw_old: got %h want %h", readdata, x);
      end
      bus_read(2, d);
      n_cmp++;
      if (d !== y) begin
         n_bad++;
         $display("FAIL rw_new: got %h want %h", d, y);
      end
   endtask

   task automatic test_busy();
      str_t a;
      logic [31:0] d;
      for (int i = 0; i < NB; i++) a[i] = 8'($urandom);
      load(a, a);
      acc_hang = 1;
      start(1, 0, 1'b1);
      bus_write(2, 32'hdeadbeef);
      start(3, 0, 1'b0);
      n_cmp++;
      if (A !== a || index !== 4'd1 || go !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_hold: A=%h idx=%0d go=%b want %h 1 1",
                  A, index, go, a);
      end
      bus_read(1, d);
      n_cmp++;
      if (d !== 32'h1) begin
         n_bad++;
         $display("FAIL busy_stat: got %h want 1", d);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (go !== 1'b0 || irq !== 1'b0 || readdata !== 32'd0) begin
         n_bad++;
         $display("FAIL busy_reset: go=%b rd=%h want 0 0",
                  go, readdata);
      end
      reset    = 1'b0;
      acc_hang = 0;
      for (int r = 0; r < 16; r++) begin
         bus_read(r, d);
         n_cmp++;
         if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_reg%0d: got %h want 0", r, d);
         end
      end
      n_cmp++;
      if (A !== '0 || B !== '0 || index !== 4'd0) begin
         n_bad++;
         $display("FAIL rst_ports: A=%h idx=%0d want 0", A, index);
      end
   endtask

   initial begin
      reset     = 1'b1;
      address   = '0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = '0;
      test_reset();
      test_upper();
      test_search();
      test_random();
      test_bad();
      test_timeout();
      test_rw_same();
      test_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
